// File: rtl/obi_vx_bridge_pkg.sv
// Shared types and constants for the OBI-slave to VX-memory-master bridge.
package obi_vx_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    VX_SEND_REQ  = 2'd1,
    VX_WAIT_RSP  = 2'd2,
    OBI_SEND_RSP = 2'd3
  } state_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/obi_vx_bridge_if.sv
// Bus bundles used by the bridge: OBI request/response and VX memory request/response.
interface obi_req_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;

  modport slave  (input req, we, be, addr, wdata, output gnt);
  modport master (output req, we, be, addr, wdata, input gnt);
endinterface

interface obi_rsp_if;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output rvalid, rdata);
  modport slave  (input rvalid, rdata);
endinterface

interface VX_mem_req_if #(
  parameter int TAG_WIDTH = 1
);
  logic                 valid;
  logic                 rw;
  logic [3:0]           byteen;
  logic [31:0]          addr;
  logic [31:0]          data;
  logic [TAG_WIDTH-1:0] tag;
  logic                 ready;

  modport master (output valid, rw, byteen, addr, data, tag, input ready);
  modport slave  (input valid, rw, byteen, addr, data, tag, output ready);
endinterface

interface VX_mem_rsp_if #(
  parameter int TAG_WIDTH = 1
);
  logic                 valid;
  logic [31:0]          data;
  logic [TAG_WIDTH-1:0] tag;
  logic                 ready;

  modport slave  (input valid, data, tag, output ready);
  modport master (output valid, data, tag, input ready);
endinterface

// File: rtl/obi_vx_timeout_cnt.sv
// Read-response watchdog for the bridge; only built with OBI_VX_TIMEOUT_EN.
`ifdef OBI_VX_TIMEOUT_EN
module obi_vx_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/obi_to_vx_mem_bridge.sv
// OBI slave -> VX memory master bridge, one transaction in flight.
// Optional read-response timeout and sticky err_o under OBI_VX_TIMEOUT_EN.
module obi_to_vx_mem_bridge
  import obi_vx_bridge_pkg::*;
#(
  parameter int TAG_WIDTH_BIT  = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  obi_req_if.slave    obi_req,
  obi_rsp_if.master   obi_rsp,
  VX_mem_req_if.master vx_mem_req,
  VX_mem_rsp_if.slave vx_mem_rsp
`ifdef OBI_VX_TIMEOUT_EN
  ,
  output logic        err_o
`endif
);

  state_t                   state_q, state_d;
  logic [TAG_WIDTH_BIT-1:0] tag_cnt_q, tag_q;
  logic                     we_q;
  logic [3:0]               be_q;
  logic [31:0]              addr_q, wdata_q, rdata_q;
  logic                     tag_match, expired;

  assign tag_match = vx_mem_rsp.valid && (vx_mem_rsp.tag == tag_q);

`ifdef OBI_VX_TIMEOUT_EN
  logic err_q;

  obi_vx_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  ((state_q == VX_SEND_REQ) && vx_mem_req.ready && !we_q),
    .enable (state_q == VX_WAIT_RSP),
    .expired(expired)
  );

  assign err_o = err_q;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
  assign expired        = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (obi_req.req) state_d = VX_SEND_REQ;
      VX_SEND_REQ:  if (vx_mem_req.ready) state_d = we_q ? OBI_SEND_RSP : VX_WAIT_RSP;
      VX_WAIT_RSP:  if (tag_match || expired) state_d = OBI_SEND_RSP;
      OBI_SEND_RSP: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // gnt is gated by rst_i so it reads 0 while reset is held, even with req high.
  always_comb begin
    obi_req.gnt      = (state_q == IDLE) && obi_req.req && !rst_i;
    vx_mem_req.valid = (state_q == VX_SEND_REQ);
    vx_mem_rsp.ready = (state_q == VX_WAIT_RSP);
    obi_rsp.rvalid   = (state_q == OBI_SEND_RSP);
  end

  assign vx_mem_req.rw     = we_q;
  assign vx_mem_req.byteen = be_q;
  assign vx_mem_req.addr   = addr_q;
  assign vx_mem_req.data   = wdata_q;
  assign vx_mem_req.tag    = tag_q;
  assign obi_rsp.rdata     = rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_cnt_q <= '0;
      tag_q     <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
`ifdef OBI_VX_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      if ((state_q == IDLE) && obi_req.req) begin
        we_q      <= obi_req.we;
        be_q      <= obi_req.be;
        addr_q    <= obi_req.addr;
        wdata_q   <= obi_req.wdata;
        tag_q     <= tag_cnt_q;
        tag_cnt_q <= tag_cnt_q + 1'b1;
      end
      if ((state_q == VX_SEND_REQ) && vx_mem_req.ready && we_q) begin
        rdata_q <= '0;
      end
      if ((state_q == VX_WAIT_RSP) && tag_match) begin
        rdata_q <= vx_mem_rsp.data;
      end
`ifdef OBI_VX_TIMEOUT_EN
      else if ((state_q == VX_WAIT_RSP) && expired) begin
        rdata_q <= TIMEOUT_RDATA;
        err_q   <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_obi_to_vx_mem_bridge.sv
// Self-checking bench for obi_to_vx_mem_bridge: directed vector table, hand sequences, random traffic.
module tb_obi_to_vx_mem_bridge;

  localparam int TW = 1;
`ifdef OBI_VX_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic clk;
  logic rst_i;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_tag = 0;

  obi_req_if                       obi_req_bus ();
  obi_rsp_if                       obi_rsp_bus ();
  VX_mem_req_if #(.TAG_WIDTH(TW))  vx_req_bus ();
  VX_mem_rsp_if #(.TAG_WIDTH(TW))  vx_rsp_bus ();
`ifdef OBI_VX_TIMEOUT_EN
  logic err_o;
`endif

  obi_to_vx_mem_bridge #(
    .TAG_WIDTH_BIT (TW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .obi_req   (obi_req_bus),
    .obi_rsp   (obi_rsp_bus),
    .vx_mem_req(vx_req_bus),
    .vx_mem_rsp(vx_rsp_bus)
`ifdef OBI_VX_TIMEOUT_EN
    ,
    .err_o     (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    int          late;
    int          drops;
    logic [31:0] rsp_data;
    logic [31:0] exp_rdata;
    logic [TW-1:0] exp_tag;
    bit          hold;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_err(input string nm, input logic exp);
`ifdef OBI_VX_TIMEOUT_EN
    chk(nm, 32'(err_o), 32'(exp));
`endif
  endtask

  // Drives one OBI transaction and plays the VX memory side; every cycle's outputs are
  // checked against the latency rules: gnt at N, VX valid for stall+1 cycles, then
  // late+drops+1 wait cycles for reads, then a single rvalid.
  task automatic run_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall, input int late,
                         input int drops, input logic [31:0] rsp_data,
                         input logic [31:0] exp_rdata, input logic [TW-1:0] exp_tag,
                         input bit hold, input string nm);
    obi_req_bus.req   = 1'b1;
    obi_req_bus.we    = we;
    obi_req_bus.be    = be;
    obi_req_bus.addr  = addr;
    obi_req_bus.wdata = wdata;
    vx_req_bus.ready  = 1'b0;
    vx_rsp_bus.valid  = 1'b0;
    #1;
    chk({nm, ".gnt"}, 32'(obi_req_bus.gnt), 32'd1);
    chk({nm, ".rvalid0"}, 32'(obi_rsp_bus.rvalid), 32'd0);
    tick();
    obi_req_bus.req   = hold;
    obi_req_bus.addr  = ~addr;
    obi_req_bus.wdata = ~wdata;
    obi_req_bus.we    = ~we;
    for (int i = 0; i <= stall; i++) begin
      vx_req_bus.ready = (i == stall);
      #1;
      chk({nm, ".vx_valid"}, 32'(vx_req_bus.valid), 32'd1);
      chk({nm, ".rw"}, 32'(vx_req_bus.rw), 32'(we));
      chk({nm, ".byteen"}, 32'(vx_req_bus.byteen), 32'(be));
      chk({nm, ".addr"}, vx_req_bus.addr, addr);
      chk({nm, ".data"}, vx_req_bus.data, wdata);
      chk({nm, ".tag"}, 32'(vx_req_bus.tag), 32'(exp_tag));
      chk({nm, ".gnt_busy"}, 32'(obi_req_bus.gnt), 32'd0);
      chk({nm, ".rvalid_early"}, 32'(obi_rsp_bus.rvalid), 32'd0);
      tick();
    end
    vx_req_bus.ready = 1'b0;
    if (!we) begin
      for (int i = 0; i < late + drops + 1; i++) begin
        vx_rsp_bus.valid = (i >= late);
        vx_rsp_bus.tag   = (i == late + drops) ? exp_tag : ~exp_tag;
        vx_rsp_bus.data  = (i == late + drops) ? rsp_data : (32'h0000_0BAD ^ 32'(i));
        #1;
        chk({nm, ".rsp_ready"}, 32'(vx_rsp_bus.ready), 32'd1);
        chk({nm, ".vx_valid_wait"}, 32'(vx_req_bus.valid), 32'd0);
        chk({nm, ".gnt_wait"}, 32'(obi_req_bus.gnt), 32'd0);
        chk({nm, ".rvalid_wait"}, 32'(obi_rsp_bus.rvalid), 32'd0);
        tick();
      end
      vx_rsp_bus.valid = 1'b0;
    end
    #1;
    chk({nm, ".rvalid"}, 32'(obi_rsp_bus.rvalid), 32'd1);
    chk({nm, ".rdata"}, obi_rsp_bus.rdata, exp_rdata);
    chk({nm, ".gnt_rsp"}, 32'(obi_req_bus.gnt), 32'd0);
    chk({nm, ".vx_valid_rsp"}, 32'(vx_req_bus.valid), 32'd0);
    tick();
    obi_req_bus.req = 1'b0;
    #1;
    chk({nm, ".rvalid_once"}, 32'(obi_rsp_bus.rvalid), 32'd0);
    model_tag = (model_tag + 1) % (1 << TW);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".gnt"}, 32'(obi_req_bus.gnt), 32'd0);
    chk({nm, ".rvalid"}, 32'(obi_rsp_bus.rvalid), 32'd0);
    chk({nm, ".rdata"}, obi_rsp_bus.rdata, 32'd0);
    chk({nm, ".vx_valid"}, 32'(vx_req_bus.valid), 32'd0);
    chk({nm, ".rw"}, 32'(vx_req_bus.rw), 32'd0);
    chk({nm, ".byteen"}, 32'(vx_req_bus.byteen), 32'd0);
    chk({nm, ".addr"}, vx_req_bus.addr, 32'd0);
    chk({nm, ".data"}, vx_req_bus.data, 32'd0);
    chk({nm, ".tag"}, 32'(vx_req_bus.tag), 32'd0);
    chk({nm, ".rsp_ready"}, 32'(vx_rsp_bus.ready), 32'd0);
    chk_err({nm, ".err"}, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic        r_we;
    logic [31:0] r_data, r_wdata;

    vecs[0] = '{1'b1, 4'hF, 32'h0000_0100, 32'hCAFE_0001, 0, 0, 0, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 4'hF, 32'h0000_0200, 32'h0, 3, 2, 0, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 4'h3, 32'h0000_0300, 32'h0, 0, 0, 0, 32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 4'hF, 32'h0000_0304, 32'h0, 0, 0, 1, 32'h0000_600D, 32'h0000_600D, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 4'hF, 32'h0000_0400, 32'h0, 0, 0, 0, 32'hA000_0001, 32'hA000_0001, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 4'hF, 32'h0000_0404, 32'h0, 0, 0, 0, 32'hA000_0002, 32'hA000_0002, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 4'hF, 32'h0000_0408, 32'h0, 0, 0, 0, 32'hA000_0003, 32'hA000_0003, 1'b0, 1'b0};

    rst_i             = 1'b1;
    obi_req_bus.req   = 1'b1;
    obi_req_bus.we    = 1'b1;
    obi_req_bus.be    = 4'hF;
    obi_req_bus.addr  = 32'h1;
    obi_req_bus.wdata = 32'h1;
    vx_req_bus.ready  = 1'b1;
    vx_rsp_bus.valid  = 1'b0;
    vx_rsp_bus.data   = '0;
    vx_rsp_bus.tag    = '0;
    #3;
    chk_reset_outputs("reset");
    tick();
    tick();
    obi_req_bus.req = 1'b0;
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].stall,
              vecs[i].late, vecs[i].drops, vecs[i].rsp_data, vecs[i].exp_rdata,
              vecs[i].exp_tag, vecs[i].hold, $sformatf("vec%0d", i));
      tick();
    end

    // Random traffic; the reference is the transaction-level latency and tag rules.
    for (int i = 0; i < 40; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_data  = $urandom;
      r_wdata = $urandom;
      run_txn(r_we, 4'($urandom_range(0, 15)), $urandom, r_wdata,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
              r_data, r_we ? 32'h0 : r_data, TW'(model_tag),
              1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Reset while waiting for a read response.
    tick();
    run_txn(1'b0, 4'hF, 32'h0000_0500, 32'h0, 0, 0, 0, 32'hA5A5_0001, 32'hA5A5_0001,
            TW'(model_tag), 1'b0, "pre_rst");
    if (model_tag != 0) begin
      tick();
      run_txn(1'b0, 4'hF, 32'h0000_0504, 32'h0, 0, 0, 0, 32'hA5A5_0002, 32'hA5A5_0002,
              TW'(model_tag), 1'b0, "pre_rst2");
    end
    tick();
    obi_req_bus.req   = 1'b1;
    obi_req_bus.we    = 1'b0;
    obi_req_bus.be    = 4'hF;
    obi_req_bus.addr  = 32'h7777_0000;
    obi_req_bus.wdata = 32'h0;
    #1;
    chk("mid_rst.gnt", 32'(obi_req_bus.gnt), 32'd1);
    tick();
    obi_req_bus.req  = 1'b0;
    vx_req_bus.ready = 1'b1;
    #1;
    chk("mid_rst.vx_valid", 32'(vx_req_bus.valid), 32'd1);
    tick();
    vx_req_bus.ready = 1'b0;
    #1;
    chk("mid_rst.waiting", 32'(vx_rsp_bus.ready), 32'd1);
    obi_req_bus.req = 1'b1;
    rst_i = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    tick();
    rst_i = 1'b0;
    obi_req_bus.req  = 1'b0;
    vx_rsp_bus.valid = 1'b1;
    vx_rsp_bus.tag   = '0;
    vx_rsp_bus.data  = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst.rvalid", 32'(obi_rsp_bus.rvalid), 32'd0);
      chk("post_rst.rsp_ready", 32'(vx_rsp_bus.ready), 32'd0);
      tick();
    end
    vx_rsp_bus.valid = 1'b0;
    model_tag = 0;
    run_txn(1'b0, 4'hF, 32'h0000_0600, 32'h0, 1, 1, 0, 32'h0BAD_F00D, 32'h0BAD_F00D,
            TW'(0), 1'b0, "post_rst_txn");

`ifdef OBI_VX_TIMEOUT_EN
    tick();
    obi_req_bus.req   = 1'b1;
    obi_req_bus.we    = 1'b0;
    obi_req_bus.addr  = 32'h0000_0700;
    #1;
    chk("tmo.gnt", 32'(obi_req_bus.gnt), 32'd1);
    tick();
    obi_req_bus.req  = 1'b0;
    vx_req_bus.ready = 1'b1;
    #1;
    chk("tmo.vx_valid", 32'(vx_req_bus.valid), 32'd1);
    tick();
    vx_req_bus.ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("tmo.rsp_ready", 32'(vx_rsp_bus.ready), 32'd1);
      chk("tmo.rvalid_early", 32'(obi_rsp_bus.rvalid), 32'd0);
      chk_err("tmo.err_early", 1'b0);
      tick();
    end
    #1;
    chk("tmo.rvalid", 32'(obi_rsp_bus.rvalid), 32'd1);
    chk("tmo.rdata", obi_rsp_bus.rdata, 32'hDEAD_BEEF);
    chk_err("tmo.err", 1'b1);
    tick();
    model_tag = (model_tag + 1) % (1 << TW);
    run_txn(1'b1, 4'hF, 32'h0000_0800, 32'h1111_2222, 0, 0, 0, 32'h0, 32'h0,
            TW'(model_tag), 1'b0, "tmo_after_wr");
    chk_err("tmo.err_sticky_wr", 1'b1);
    tick();
    run_txn(1'b0, 4'hF, 32'h0000_0804, 32'h0, 0, 1, 0, 32'h3333_4444, 32'h3333_4444,
            TW'(model_tag), 1'b0, "tmo_after_rd");
    chk_err("tmo.err_sticky_rd", 1'b1);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
